// File: rtl/tcp_tx_arbiter.sv
// Round-robin framed-source arbiter onto the SiTCP TX byte stream.
// Each frame is prefixed by {HDR_MAGIC, source}; frames are dropped when no connection.
module tcp_tx_arbiter #(
  parameter int          N_SRC     = 4,
  parameter logic [3:0]  HDR_MAGIC = 4'hA
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               tcp_open_ack,
  input  logic               tcp_tx_full,
  output logic               tcp_tx_wr,
  output logic [7:0]         tcp_txd,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_last,
  output logic [N_SRC-1:0]   src_ready,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int GW = $clog2(N_SRC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_FLUSH,
    S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic            wr_q, wr_d;
  logic [7:0]      txd_q, txd_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic            pick_found;
  logic [GW-1:0]   pick_idx;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;

  assign g_valid   = src_valid[grant_q];
  assign g_last    = src_last[grant_q];
  assign g_data    = src_data[{grant_q, 3'b000} +: 8];

  assign tcp_tx_wr = wr_q;
  assign tcp_txd   = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  // Search for the first valid source starting just after the last grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      int j;
      j = (int'(rr_q) + k) % N_SRC;
      if (!pick_found && src_valid[j]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(j);
      end
    end
  end

  // Next-state, handshake and output-byte decode.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    wr_d        = 1'b0;
    txd_d       = txd_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    src_ready   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          rr_d    = pick_idx;
          state_d = tcp_open_ack ? S_HDR : S_DROP;
        end
      end
      S_HDR: begin
        if (!tcp_open_ack) begin
          state_d = S_FLUSH;
        end else if (!tcp_tx_full) begin
          wr_d    = 1'b1;
          txd_d   = {HDR_MAGIC, 4'(grant_q)};
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!tcp_open_ack) begin
          state_d = S_FLUSH;
        end else begin
          src_ready[grant_q] = ~tcp_tx_full;
          if (g_valid && !tcp_tx_full) begin
            wr_d  = 1'b1;
            txd_d = g_data;
            if (g_last) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
              state_d     = S_IDLE;
            end
          end
        end
      end
      S_FLUSH, S_DROP: begin
        src_ready[grant_q] = 1'b1;
        if (g_valid && g_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, grant, output and counter registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= GW'(N_SRC - 1);
      wr_q        <= 1'b0;
      txd_q       <= 8'h00;
      frame_cnt_q <= 16'h0000;
      drop_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      wr_q        <= wr_d;
      txd_q       <= txd_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
